// File: rtl/stream_mux_pkg.sv
// Shared types and the round-robin search function used by the N:1 stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bound on channel count the search function can handle.
  localparam int MAX_CH = 64;
  localparam int IDX_W  = 6;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } grant_t;

  // First requesting channel at or above ptr, wrapping nch-1 -> 0.
  function automatic grant_t rr_search(input logic [MAX_CH-1:0] req,
                                       input int unsigned       ptr,
                                       input int unsigned       nch);
    grant_t      g;
    int unsigned k;
    g = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      k = ptr + i;
      if (k >= nch) k = k - nch;
      if (i < nch && !g.found && req[k[IDX_W-1:0]]) begin
        g.found = 1'b1;
        g.idx   = k[IDX_W-1:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin grant search: picks the first valid channel from ptr upward and
// computes the pointer value that follows a grant.
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx,
  output logic [SELW-1:0] next_ptr
);
  import stream_mux_pkg::*;

  grant_t g;

  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch behind.
  always_comb begin
    g         = rr_search(MAX_CH'(req), 32'(ptr), NCH);
    gnt_valid = en & g.found;
    gnt_idx   = SELW'(g.idx);
    next_ptr  = ptr;
    if (gnt_valid) next_ptr = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/stream_mux_n.sv
// N:1 valid/ready stream multiplexer with one output register, fixed-select and
// round-robin modes. Optional out_parity port is enabled by STREAM_MUX_PARITY_EN.
module stream_mux_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef STREAM_MUX_PARITY_EN
  output logic [SELW-1:0]      cur_ch,
  output logic                 out_parity
`else
  output logic [SELW-1:0]      cur_ch
`endif
);
  import stream_mux_pkg::*;

  localparam int NSEL = 1 << SELW;

  state_e           state;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  rr_next;
  logic             rr_gnt;
  logic             can_load;
  logic             fix_gnt;
  logic             grant;
  logic [SELW-1:0]  g;
  logic [WIDTH-1:0] sel_data;
  logic [NSEL-1:0]  valid_ext;

  assign can_load  = (state == ST_EMPTY) | out_ready;
  // Padded so that an out-of-range sel indexes a zero rather than past the vector.
  assign valid_ext = NSEL'(in_valid);

  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
    .req      (in_valid),
    .ptr      (rr_ptr),
    .en       (!rst && mode == MODE_RR && can_load),
    .gnt_valid(rr_gnt),
    .gnt_idx  (rr_idx),
    .next_ptr (rr_next)
  );

  assign fix_gnt  = !rst && mode == MODE_FIXED && can_load &&
                    (int'(sel) < NCH) && valid_ext[sel];
  assign grant    = fix_gnt | rr_gnt;
  assign g        = (mode == MODE_RR) ? rr_idx : sel;
  assign sel_data = in_data[int'(g)*WIDTH +: WIDTH];
  assign in_ready = grant ? (NCH'(1) << g) : '0;

  // NOTE: sequential state uses non-blocking assignments; the reset branch clears every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_data  <= '0;
      out_valid <= 1'b0;
      cur_ch    <= '0;
      rr_ptr    <= '0;
`ifdef STREAM_MUX_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      if (grant) begin
        state     <= ST_FULL;
        out_data  <= sel_data;
        out_valid <= 1'b1;
        cur_ch    <= g;
`ifdef STREAM_MUX_PARITY_EN
        out_parity <= ^sel_data;
`endif
      end else if (out_ready) begin
        state     <= ST_EMPTY;
        out_valid <= 1'b0;
      end
      // rr_next equals rr_ptr unless a scan-mode grant happened.
      rr_ptr <= rr_next;
    end
  end

endmodule
